// File: rtl/vend_pkg.sv
// Shared encodings for the vending-machine session controller:
// session states, coin codes and purchase codes seen by the coin_memory datapath.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_INSERT = 2'b01,
        ST_HOLD   = 2'b10,
        ST_CHANGE = 2'b11
    } vend_state_t;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_1    = 3'b001;
    localparam logic [2:0] COIN_5    = 3'b010;
    localparam logic [2:0] COIN_10   = 3'b100;

    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_B    = 2'b01;

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector. WHOLE=1 treats the input as one vector
// (fires only when the previous sample was all zero); WHOLE=0 detects per bit.
module edge_pulse #(
    parameter int W     = 3,
    parameter bit WHOLE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] cur_reg;
    logic [W-1:0] prev_reg;
    logic         armed_reg;

    // The first sample after reset release primes the history with itself, so a
    // level already high at release is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_reg   <= '0;
            prev_reg  <= '0;
            armed_reg <= 1'b0;
        end else begin
            cur_reg   <= din;
            prev_reg  <= armed_reg ? cur_reg : din;
            armed_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        if (WHOLE) begin : g_whole
            assign rise = (prev_reg == '0) ? cur_reg : '0;
        end else begin : g_bits
            for (gi = 0; gi < W; gi++) begin : g_bit
                assign rise[gi] = cur_reg[gi] & ~prev_reg[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/vend_controller.sv
// Session controller for the vending datapath: turns front-panel levels into
// single-cycle coin/purchase pulses, decides purchases and times out sessions.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE_A       = 25,
    parameter int PRICE_B       = 50,
    parameter int TIMEOUT       = 1000,
    parameter int CHANGE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] coin_in,
    input  logic       sel_a,
    input  logic       sel_b,
    input  logic       finish,
    input  logic [7:0] left,
    input  logic       overflow,
    output logic [1:0] state,
    output logic [2:0] coin,
    output logic [1:0] ab,
    output logic       dispense_a,
    output logic       dispense_b,
    output logic       short,
    output logic       change_done
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = $clog2(CHANGE_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CHANGE_CYCLES - 1);
    localparam logic [7:0]    PRICE_A8 = 8'(PRICE_A);
    localparam logic [7:0]    PRICE_B8 = 8'(PRICE_B);

    logic [2:0] coin_rise;
    logic [2:0] btn_rise;
    logic       ovf_reg;

    edge_pulse #(.W(3), .WHOLE(1'b1)) u_coin_edge (
        .clk   (clk),
        .reset (reset),
        .din   (coin_in),
        .rise  (coin_rise)
    );

    edge_pulse #(.W(3), .WHOLE(1'b0)) u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .din   ({finish, sel_b, sel_a}),
        .rise  (btn_rise)
    );

    logic coin_ev, sel_a_ev, sel_b_ev, finish_ev;
    assign coin_ev   = $onehot(coin_rise);
    assign sel_a_ev  = btn_rise[0] & ~btn_rise[1];
    assign sel_b_ev  = btn_rise[1] & ~btn_rise[0];
    assign finish_ev = btn_rise[2];

    vend_state_t   state_reg, state_next;
    logic [2:0]    coin_reg, coin_next;
    logic [1:0]    ab_reg, ab_next;
    logic          disp_a_reg, disp_a_next;
    logic          disp_b_reg, disp_b_next;
    logic          short_reg, short_next;
    logic          done_reg, done_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic [CW-1:0] ccnt_reg, ccnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            coin_reg   <= COIN_NONE;
            ab_reg     <= AB_NONE;
            disp_a_reg <= 1'b0;
            disp_b_reg <= 1'b0;
            short_reg  <= 1'b0;
            done_reg   <= 1'b0;
            tcnt_reg   <= '0;
            ccnt_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            coin_reg   <= coin_next;
            ab_reg     <= ab_next;
            disp_a_reg <= disp_a_next;
            disp_b_reg <= disp_b_next;
            short_reg  <= short_next;
            done_reg   <= done_next;
            tcnt_reg   <= tcnt_next;
            ccnt_reg   <= ccnt_next;
            ovf_reg    <= overflow;
        end
    end

    always_comb begin
        state_next  = state_reg;
        coin_next   = COIN_NONE;
        ab_next     = AB_NONE;
        disp_a_next = 1'b0;
        disp_b_next = 1'b0;
        short_next  = 1'b0;
        tcnt_next   = '0;
        ccnt_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (sel_a_ev || sel_b_ev) begin
                    short_next = 1'b1;
                end else if (coin_ev) begin
                    coin_next  = coin_rise;
                    state_next = ST_INSERT;
                end
            end
            ST_INSERT: begin
                // Priority: overflow, finish, select, coin, then timeout.
                if (ovf_reg) begin
                    state_next = ST_CHANGE;
                end else if (finish_ev) begin
                    state_next = (left == 8'd0) ? ST_IDLE : ST_CHANGE;
                end else if (sel_a_ev) begin
                    if (left >= PRICE_A8) begin
                        ab_next     = AB_A;
                        disp_a_next = 1'b1;
                        state_next  = ST_HOLD;
                    end else begin
                        short_next = 1'b1;
                    end
                end else if (sel_b_ev) begin
                    if (left >= PRICE_B8) begin
                        ab_next     = AB_B;
                        disp_b_next = 1'b1;
                        state_next  = ST_HOLD;
                    end else begin
                        short_next = 1'b1;
                    end
                end else if (coin_ev) begin
                    coin_next = coin_rise;
                end else if (tcnt_reg == T_LAST) begin
                    state_next = ST_CHANGE;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end
            ST_HOLD: begin
                state_next = ST_INSERT;
            end
            ST_CHANGE: begin
                if (ccnt_reg == C_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    ccnt_next = ccnt_reg + CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // change_done is registered alongside the state that marks the last CHANGE cycle.
        done_next = (state_next == ST_CHANGE) && (ccnt_next == C_LAST);
    end

    assign state       = state_reg;
    assign coin        = coin_reg;
    assign ab          = ab_reg;
    assign dispense_a  = disp_a_reg;
    assign dispense_b  = disp_b_reg;
    assign short       = short_reg;
    assign change_done = done_reg;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller (TIMEOUT shortened to 8): one linear
// sequence of stimulus steps with hand-computed expectations after each edge.
module tb_vend_controller;
    import vend_pkg::*;

    logic       clk;
    logic       reset;
    logic [2:0] coin_in;
    logic       sel_a, sel_b, finish, overflow;
    logic [7:0] left;
    logic [1:0] state;
    logic [2:0] coin;
    logic [1:0] ab;
    logic       dispense_a, dispense_b, short, change_done;

    int total = 0;
    int bad   = 0;

    vend_controller #(
        .PRICE_A       (25),
        .PRICE_B       (50),
        .TIMEOUT       (8),
        .CHANGE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_in     (coin_in),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .finish      (finish),
        .left        (left),
        .overflow    (overflow),
        .state       (state),
        .coin        (coin),
        .ab          (ab),
        .dispense_a  (dispense_a),
        .dispense_b  (dispense_b),
        .short       (short),
        .change_done (change_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; coin_in = 3'b000; sel_a = 1'b0; sel_b = 1'b0;
        finish = 1'b0; overflow = 1'b0; left = 8'd0;

        #20;
        check("rst_state", 8'(state), 8'(ST_IDLE));
        check("rst_coin", 8'(coin), 8'h00);
        check("rst_ab", 8'(ab), 8'h00);
        check("rst_disp_a", 8'(dispense_a), 8'h00);
        check("rst_disp_b", 8'(dispense_b), 8'h00);
        check("rst_short", 8'(short), 8'h00);
        check("rst_done", 8'(change_done), 8'h00);
        #20;
        reset = 1'b1;
        step();
        check("idle_after_release", 8'(state), 8'(ST_IDLE));

        // held coin level produces exactly one pulse
        coin_in = COIN_1;
        step();
        check("coin1_latency_coin", 8'(coin), 8'h00);
        check("coin1_latency_state", 8'(state), 8'(ST_IDLE));
        step();
        check("coin1_pulse", 8'(coin), 8'(COIN_1));
        check("coin1_to_insert", 8'(state), 8'(ST_INSERT));
        step();
        check("coin1_held_no_repeat", 8'(coin), 8'h00);
        coin_in = 3'b000;
        step();
        check("coin1_quiet", 8'(coin), 8'h00);

        // purchase A with enough balance
        left = 8'd30; sel_a = 1'b1;
        step();
        check("buy_a_latency", 8'(ab), 8'h00);
        step();
        check("buy_a_ab", 8'(ab), 8'(AB_A));
        check("buy_a_disp", 8'(dispense_a), 8'h01);
        check("buy_a_disp_b_low", 8'(dispense_b), 8'h00);
        check("buy_a_hold", 8'(state), 8'(ST_HOLD));
        sel_a = 1'b0; left = 8'd5;
        step();
        check("buy_a_ab_end", 8'(ab), 8'h00);
        check("buy_a_disp_end", 8'(dispense_a), 8'h00);
        check("hold_back_insert", 8'(state), 8'(ST_INSERT));

        // purchase B with insufficient balance
        sel_b = 1'b1;
        step();
        check("short_b_latency", 8'(short), 8'h00);
        step();
        check("short_b_pulse", 8'(short), 8'h01);
        check("short_b_no_ab", 8'(ab), 8'h00);
        check("short_b_state", 8'(state), 8'(ST_INSERT));
        sel_b = 1'b0;
        step();
        check("short_b_end", 8'(short), 8'h00);

        // simultaneous selects are no event
        left = 8'd99; sel_a = 1'b1; sel_b = 1'b1;
        step();
        step();
        check("both_sel_no_ab", 8'(ab), 8'h00);
        check("both_sel_no_short", 8'(short), 8'h00);
        check("both_sel_state", 8'(state), 8'(ST_INSERT));
        sel_a = 1'b0; sel_b = 1'b0;
        step();
        check("both_sel_no_ab_later", 8'(ab), 8'h00);

        // finish beats coin; nonzero balance goes to CHANGE for 4 cycles
        left = 8'd10; coin_in = COIN_10; finish = 1'b1;
        step();
        check("finish_latency", 8'(state), 8'(ST_INSERT));
        step();
        check("finish_coin_dropped", 8'(coin), 8'h00);
        check("finish_change_1", 8'(state), 8'(ST_CHANGE));
        check("finish_done_1", 8'(change_done), 8'h00);
        coin_in = 3'b000; finish = 1'b0;
        step();
        check("finish_change_2", 8'(state), 8'(ST_CHANGE));
        check("finish_done_2", 8'(change_done), 8'h00);
        step();
        check("finish_change_3", 8'(state), 8'(ST_CHANGE));
        check("finish_done_3", 8'(change_done), 8'h00);
        step();
        check("finish_change_4", 8'(state), 8'(ST_CHANGE));
        check("finish_done_4", 8'(change_done), 8'h01);
        step();
        check("finish_to_idle", 8'(state), 8'(ST_IDLE));
        check("finish_done_end", 8'(change_done), 8'h00);

        // overflow forces CHANGE; coins during CHANGE are dropped
        coin_in = COIN_5;
        step();
        step();
        check("coin5_pulse", 8'(coin), 8'(COIN_5));
        check("coin5_insert", 8'(state), 8'(ST_INSERT));
        coin_in = 3'b000; overflow = 1'b1;
        step();
        check("ovf_latency", 8'(state), 8'(ST_INSERT));
        step();
        check("ovf_change", 8'(state), 8'(ST_CHANGE));
        overflow = 1'b0; coin_in = COIN_1;
        step();
        check("change_coin_drop_1", 8'(coin), 8'h00);
        step();
        check("change_coin_drop_2", 8'(coin), 8'h00);
        check("change_still", 8'(state), 8'(ST_CHANGE));
        coin_in = 3'b000;
        step();
        check("ovf_done", 8'(change_done), 8'h01);
        step();
        check("ovf_idle", 8'(state), 8'(ST_IDLE));

        // timeout with no events: INSERT lasts 8 cycles
        coin_in = COIN_10;
        step();
        step();
        check("to_coin_pulse", 8'(coin), 8'(COIN_10));
        check("to_insert", 8'(state), 8'(ST_INSERT));
        coin_in = 3'b000;
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("to_wait_%0d", i), 8'(state), 8'(ST_INSERT));
        end
        step();
        check("to_change", 8'(state), 8'(ST_CHANGE));
        step();
        step();
        step();
        check("to_done", 8'(change_done), 8'h01);
        step();
        check("to_idle", 8'(state), 8'(ST_IDLE));

        // a coin mid-count restarts the timeout
        coin_in = COIN_1;
        step();
        step();
        check("rs_insert", 8'(state), 8'(ST_INSERT));
        coin_in = 3'b000;
        repeat (4) step();
        coin_in = COIN_5;
        step();
        coin_in = 3'b000;
        step();
        check("rs_coin_pulse", 8'(coin), 8'(COIN_5));
        check("rs_coin_state", 8'(state), 8'(ST_INSERT));
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("rs_wait_%0d", i), 8'(state), 8'(ST_INSERT));
        end
        step();
        check("rs_change", 8'(state), 8'(ST_CHANGE));
        repeat (4) step();
        check("rs_idle", 8'(state), 8'(ST_IDLE));

        // reset during HOLD, select held through release
        coin_in = COIN_5;
        step();
        step();
        check("hr_insert", 8'(state), 8'(ST_INSERT));
        coin_in = 3'b000; left = 8'd60; sel_b = 1'b1;
        step();
        step();
        check("hr_ab_b", 8'(ab), 8'(AB_B));
        check("hr_disp_b", 8'(dispense_b), 8'h01);
        check("hr_hold", 8'(state), 8'(ST_HOLD));
        #2;
        reset = 1'b0; sel_b = 1'b0; sel_a = 1'b1;
        #1;
        check("hr_async_state", 8'(state), 8'(ST_IDLE));
        check("hr_async_ab", 8'(ab), 8'h00);
        check("hr_async_disp_b", 8'(dispense_b), 8'h00);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hr_held_no_short_%0d", i), 8'(short), 8'h00);
            check($sformatf("hr_held_idle_%0d", i), 8'(state), 8'(ST_IDLE));
        end
        coin_in = COIN_1;
        step();
        step();
        check("hr_reenter_insert", 8'(state), 8'(ST_INSERT));
        check("hr_held_no_ab", 8'(ab), 8'h00);
        coin_in = 3'b000;
        step();
        check("hr_held_no_ab_2", 8'(ab), 8'h00);
        sel_a = 1'b0; left = 8'd30;
        step();
        sel_a = 1'b1;
        step();
        check("hr_toggle_latency", 8'(ab), 8'h00);
        step();
        check("hr_toggle_ab", 8'(ab), 8'(AB_A));
        check("hr_toggle_disp", 8'(dispense_a), 8'h01);
        check("hr_toggle_hold", 8'(state), 8'(ST_HOLD));
        sel_a = 1'b0;
        step();
        check("hr_back_insert", 8'(state), 8'(ST_INSERT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
